nibble_serial_adder_ctrl: RTL and testbench

Multi-cycle controller that sequences one NIBBLE-bit ripple adder stage across a WIDTH-bit add, one nibble per cycle, least-significant nibble first. The carry is registered between nibbles. Operands enter on a valid/ready handshake and the result leaves on a valid/ready handshake. It replaces a full-width combinational adder where area matters more than latency.

---
 rtl/nibble_serial_adder_ctrl.sv | 125 ++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Multi-cycle adder controller. A single NIBBLE-bit ripple stage is reused
// across the whole WIDTH-bit add. It processes one nibble per clock,
// least-significant nibble first, and keeps the carry in a register between
// nibbles. Operands arrive on a valid/ready handshake and the result leaves
// on a valid/ready handshake. Every output comes from a flop, so no
// combinational path exists from any input to any output.
// WIDTH must be an integer multiple of NIBBLE.

module nibble_serial_adder_ctrl #(
   parameter int WIDTH  = 8,
   parameter int NIBBLE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             busy
);

   localparam int NUM = WIDTH / NIBBLE;
   localparam int CW  = (NUM > 1) ? $clog2(NUM) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              r_state;
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic                r_carry;
   logic [CW-1:0]       r_cnt;
   logic [WIDTH-1:0]    r_sum;
   logic                r_cout;
   logic                r_outValid;
   logic                r_busy;
   logic                r_inReady;

   logic [NIBBLE-1:0]   w_aNib;
   logic [NIBBLE-1:0]   w_bNib;
   logic [NIBBLE:0]     w_stageSum;
   logic                w_lastNib;

   // The shared nibble adder works on the nibble that the counter selects
   // and adds in the carry held from the previous nibble.
   always_comb begin
      w_aNib     = r_a[r_cnt*NIBBLE +: NIBBLE];
      w_bNib     = r_b[r_cnt*NIBBLE +: NIBBLE];
      w_stageSum = {1'b0, w_aNib} + {1'b0, w_bNib} + {{NIBBLE{1'b0}}, r_carry};
      w_lastNib  = (r_cnt == CW'(NUM - 1));
   end

   // Sequencing FSM. It holds the operand and result registers and keeps the
   // handshake flags registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_carry    <= 1'b0;
         r_cnt      <= '0;
         r_sum      <= '0;
         r_cout     <= 1'b0;
         r_outValid <= 1'b0;
         r_busy     <= 1'b0;
         r_inReady  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a       <= A;
                  r_b       <= B;
                  r_carry   <= Cin;
                  r_cnt     <= '0;
                  r_sum     <= '0;
                  r_inReady <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= ADD;
               end
            end
            ADD: begin
               r_sum[r_cnt*NIBBLE +: NIBBLE] <= w_stageSum[NIBBLE-1:0];
               r_carry <= w_stageSum[NIBBLE];
               if (w_lastNib) begin
                  r_cout     <= w_stageSum[NIBBLE];
                  r_outValid <= 1'b1;
                  r_state    <= DONE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_outValid <= 1'b0;
                  r_busy     <= 1'b0;
                  r_inReady  <= 1'b1;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_outValid <= 1'b0;
               r_busy     <= 1'b0;
               r_inReady  <= 1'b1;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_inReady;
   assign out_valid = r_outValid;
   assign busy      = r_busy;
   assign Sum       = r_sum;
   assign Cout      = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl
// Scoreboard bench for the nibble-serial adder controller. Every accepted
// operation pushes its reference {Cout, Sum} (A + B + Cin) onto a queue.
// Each scenario task pops that entry and compares it when the result
// handshake happens.

module tb_nibble_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] A;
   logic [7:0] B;
   logic       Cin;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] Sum;
   logic       Cout;
   logic       busy;

   int         checks = 0;
   int         errors = 0;
   logic [8:0] expQ[$];

   nibble_serial_adder_ctrl #(.WIDTH(8), .NIBBLE(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Sum       (Sum),
      .Cout      (Cout),
      .busy      (busy)
   );

   // 10-unit clock period.
   always #5 clk = ~clk;

   // Global watchdog so that the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Presents one operand set for a single accepting edge and records the
   // reference result.
   task automatic sendOp(input logic [7:0] a, input logic [7:0] b, input logic c);
      @(negedge clk);
      A        = a;
      B        = b;
      Cin      = c;
      in_valid = 1'b1;
      expQ.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Waits, within a cycle budget, for out_valid; samples at the falling edge.
   task automatic waitOut(output bit timedOut);
      int n = 0;
      while (out_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      timedOut = (out_valid !== 1'b1);
   endtask

   // Performs one output handshake cycle.
   task automatic takeResult();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = '0;
      B         = '0;
      Cin       = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, busy, Cout, Sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("[TB] FAIL reset_state: got rdy/vld/busy/cout/sum=%b%b%b%b/%h want 1000/00",
                  in_ready, out_valid, busy, Cout, Sum);
      end
   endtask

   task automatic test_basic();
      logic [8:0] exp;
      sendOp(8'h92, 8'hAC, 1'b0);
      @(negedge clk);
      checks++;
      if ({out_valid, busy, in_ready} !== 3'b010) begin
         errors++;
         $display("[TB] FAIL basic_after_accept: vld/busy/rdy=%b%b%b want 010", out_valid, busy, in_ready);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_latency_early: out_valid=%b want 0 after edge k+1", out_valid);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, busy, in_ready} !== 3'b110) begin
         errors++;
         $display("[TB] FAIL basic_latency: vld/busy/rdy=%b%b%b want 110 after edge k+2", out_valid, busy, in_ready);
      end
      exp = expQ.pop_front();
      checks++;
      if ({Cout, Sum} !== exp || exp !== 9'h13E) begin
         errors++;
         $display("[TB] FAIL basic_sum: got %h want %h (ref 13E)", {Cout, Sum}, exp);
      end
      takeResult();
   endtask

   task automatic test_carry();
      logic [8:0] exp;
      bit to;
      logic [7:0] aV[2] = '{8'hFF, 8'h0F};
      logic [7:0] bV[2] = '{8'h00, 8'h01};
      logic       cV[2] = '{1'b1, 1'b0};
      for (int i = 0; i < 2; i++) begin
         sendOp(aV[i], bV[i], cV[i]);
         waitOut(to);
         exp = expQ.pop_front();
         checks++;
         if (to) begin
            errors++;
            $display("[TB] FAIL carry_timeout[%0d]: out_valid=%b want 1", i, out_valid);
         end else if ({Cout, Sum} !== exp) begin
            errors++;
            $display("[TB] FAIL carry_sum[%0d]: got %h want %h", i, {Cout, Sum}, exp);
         end
         takeResult();
      end
   endtask

   task automatic test_backpressure();
      logic [8:0] exp;
      bit to;
      sendOp(8'hEA, 8'h92, 1'b0);
      waitOut(to);
      exp = expQ.pop_front();
      checks++;
      if (to) begin
         errors++;
         $display("[TB] FAIL bp_timeout: out_valid=%b want 1", out_valid);
      end
      A        = 8'h11;
      B        = 8'h00;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({out_valid, in_ready, Cout, Sum} !== {1'b1, 1'b0, exp}) begin
            errors++;
            $display("[TB] FAIL bp_hold[%0d]: vld/rdy/cout/sum=%b%b%b/%h want 10/%h",
                     i, out_valid, in_ready, Cout, Sum, exp);
         end
      end
      in_valid = 1'b0;
      takeResult();
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
         errors++;
         $display("[TB] FAIL bp_release: vld/rdy/busy=%b%b%b want 010", out_valid, in_ready, busy);
      end
      checks++;
      if ({Cout, Sum} !== 9'h17C) begin
         errors++;
         $display("[TB] FAIL bp_idle_hold: got %h want 17C", {Cout, Sum});
      end
      sendOp(8'h11, 8'h22, 1'b0);
      waitOut(to);
      exp = expQ.pop_front();
      checks++;
      if (to || {Cout, Sum} !== exp) begin
         errors++;
         $display("[TB] FAIL bp_next: got %h want %h (timeout=%0d)", {Cout, Sum}, exp, to);
      end
      takeResult();
   endtask

   task automatic test_operand_change();
      logic [8:0] exp;
      bit to;
      sendOp(8'h12, 8'h34, 1'b0);
      A   = 8'hFF;
      B   = 8'hFF;
      Cin = 1'b1;
      waitOut(to);
      exp = expQ.pop_front();
      checks++;
      if (to || {Cout, Sum} !== exp) begin
         errors++;
         $display("[TB] FAIL operand_change: got %h want %h (timeout=%0d)", {Cout, Sum}, exp, to);
      end
      takeResult();
   endtask

   task automatic test_reset_mid();
      logic [8:0] exp;
      bit to;
      @(negedge clk);
      A        = 8'h55;
      B        = 8'h66;
      Cin      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({Sum, Cout, out_valid, busy} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL reset_mid: sum/cout/vld/busy=%h/%b%b%b want 00/000", Sum, Cout, out_valid, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL reset_mid_release: rdy/vld=%b%b want 10", in_ready, out_valid);
      end
      sendOp(8'h01, 8'h01, 1'b0);
      waitOut(to);
      exp = expQ.pop_front();
      checks++;
      if (to || {Cout, Sum} !== exp) begin
         errors++;
         $display("[TB] FAIL reset_mid_fresh: got %h want %h (timeout=%0d)", {Cout, Sum}, exp, to);
      end
      takeResult();
   endtask

   task automatic test_back_to_back();
      logic [8:0] exp;
      bit to;
      for (int i = 0; i < 20; i++) begin
         sendOp(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         waitOut(to);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         exp = expQ.pop_front();
         checks++;
         if (to || {Cout, Sum} !== exp) begin
            errors++;
            $display("[TB] FAIL stream[%0d]: got %h want %h (timeout=%0d)", i, {Cout, Sum}, exp, to);
         end
         takeResult();
         #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stream_once[%0d]: out_valid=%b want 0 after handshake", i, out_valid);
         end
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL stream_drain: queue size %0d want 0", expQ.size());
      end
   endtask

   // Runs the scenarios in sequence and prints the summary.
   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_backpressure();
      test_operand_change();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
